ppt_input_conditioner: RTL

Parametrised input front end for the presentation-controller design. It takes WIDTH raw, asynchronous button or switch lines and processes each one through a synchronizer and a debouncer. It produces a debounced level per channel, one-cycle rise and fall pulses, and a small event FIFO that the controller FSM drains with a valid/ready handshake. It replaces the plain registered capture of `ui_in` in the top level.

---
 rtl/ppt_input_conditioner_if.sv | 41 ++++
 rtl/ppt_input_conditioner.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ppt_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : ppt_input_conditioner_if
// Description : Signal bundle between the input conditioner and the
//               presentation-controller FSM that consumes its events.
//               master : the conditioner (drives levels, pulses, events)
//               slave  : the consumer/stimulus side (drives raw inputs,
//                        enable, pop and overflow clear)
// Signals     : ena, in_raw[WIDTH], evt_ready, clr_overflow     (to master)
//               level_out, rise_pulse, fall_pulse [WIDTH],
//               evt_valid, evt_data[CH_W:0], evt_overflow         (from master)
// Revision    : 1.0 - initial release
// ============================================================================
interface ppt_input_conditioner_if #(
    parameter int WIDTH = 8
);
    localparam int CH_W = $clog2(WIDTH);

    logic             ena;
    logic [WIDTH-1:0] in_raw;
    logic             evt_ready;
    logic             clr_overflow;

    logic [WIDTH-1:0] level_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic             evt_valid;
    logic [CH_W:0]    evt_data;
    logic             evt_overflow;

    modport master (
        input  ena, in_raw, evt_ready, clr_overflow,
        output level_out, rise_pulse, fall_pulse, evt_valid, evt_data, evt_overflow
    );

    modport slave (
        output ena, in_raw, evt_ready, clr_overflow,
        input  level_out, rise_pulse, fall_pulse, evt_valid, evt_data, evt_overflow
    );
endinterface
`default_nettype wire

// File: rtl/ppt_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : ppt_input_conditioner
// Description : Per-channel synchronizer + debouncer for WIDTH raw button /
//               switch lines. Produces debounced levels, one-cycle rise/fall
//               pulses and a show-ahead event FIFO ({pol, ch}, pol=1 = rise)
//               fed by a lowest-channel-first arbiter over pending flags.
// Ports       : clk    - single clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - ppt_input_conditioner_if.master (ena, in_raw,
//                        level_out, rise/fall_pulse, evt_valid/data/ready,
//                        evt_overflow, clr_overflow)
// Revision    : 1.0 - initial release
// ============================================================================
module ppt_input_conditioner #(
    parameter int   WIDTH           = 8,
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 1000,
    parameter int   FIFO_DEPTH      = 4,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ppt_input_conditioner_if.master  bus
);
    localparam int CH_W  = $clog2(WIDTH);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Synchronizer chain: free-running, independent of ena
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= {WIDTH{RESET_LEVEL}};
            end
        end else begin
            sync_q[0] <= bus.in_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce: accept a change only after DEBOUNCE_CYCLES consecutive
    // cycles of disagreement with the current level.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] level_q;
    logic [WIDTH-1:0] flip;

    for (genvar c = 0; c < WIDTH; c++) begin : g_ch
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             flip_c;

        always_comb begin
            cnt_d  = cnt_q;
            flip_c = 1'b0;
            if (bus.ena) begin
                if (sync_s[c] == level_q[c]) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d  = '0;
                    flip_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign flip[c] = flip_c;
    end

    // The new level equals the synchronized value at the flip, so the
    // flip polarity comes straight from sync_s. flip is already gated by
    // ena, which also forces the pulses low while frozen.
    logic [WIDTH-1:0] flip_rise;
    logic [WIDTH-1:0] flip_fall;

    assign flip_rise = flip &  sync_s;
    assign flip_fall = flip & ~sync_s;

    // ------------------------------------------------------------------
    // Arbiter over pending flags: lowest channel wins, rise before fall
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] pend_rise_q, pend_rise_d;
    logic [WIDTH-1:0] pend_fall_q, pend_fall_d;
    logic             any_pend;
    logic [CH_W-1:0]  sel_ch;
    logic             sel_pol;

    always_comb begin
        any_pend = 1'b0;
        sel_ch   = '0;
        sel_pol  = 1'b0;
        // Scan downward so the last hit (lowest index) wins.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend_rise_q[i] || pend_fall_q[i]) begin
                any_pend = 1'b1;
                sel_ch   = CH_W'(i);
                sel_pol  = pend_rise_q[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO control
    // ------------------------------------------------------------------
    logic [CH_W:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [PTR_W:0]   count_q;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic [WIDTH-1:0] sel_onehot;
    logic [WIDTH-1:0] clr_rise;
    logic [WIDTH-1:0] clr_fall;
    logic             ovf_set;
    logic             ovf_q;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FIFO_FULL);
    assign pop        = !fifo_empty && bus.evt_ready;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign push       = bus.ena && any_pend && (!fifo_full || pop);

    assign sel_onehot = WIDTH'(1) << sel_ch;
    assign clr_rise   = {WIDTH{push &&  sel_pol}} & sel_onehot;
    assign clr_fall   = {WIDTH{push && !sel_pol}} & sel_onehot;

    // A flip onto a flag that survives this cycle cannot be recorded.
    assign ovf_set = |(flip_rise & pend_rise_q & ~clr_rise) |
                     |(flip_fall & pend_fall_q & ~clr_fall);

    assign pend_rise_d = flip_rise | (pend_rise_q & ~clr_rise);
    assign pend_fall_d = flip_fall | (pend_fall_q & ~clr_fall);

    // ------------------------------------------------------------------
    // Level, pulse, pending and overflow registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q     <= {WIDTH{RESET_LEVEL}};
            rise_q      <= '0;
            fall_q      <= '0;
            pend_rise_q <= '0;
            pend_fall_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            level_q     <= level_q ^ flip;
            rise_q      <= flip_rise;
            fall_q      <= flip_fall;
            pend_rise_q <= pend_rise_d;
            pend_fall_q <= pend_fall_d;
            ovf_q       <= ovf_set | (ovf_q & ~bus.clr_overflow);
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage (pointers wrap naturally: depth is a power of two)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= {sel_pol, sel_ch};
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.level_out    = level_q;
    assign bus.rise_pulse   = rise_q;
    assign bus.fall_pulse   = fall_q;
    assign bus.evt_valid    = !fifo_empty;
    assign bus.evt_data     = fifo_empty ? '0 : mem_q[rd_q];
    assign bus.evt_overflow = ovf_q;

endmodule
`default_nettype wire
